// File: rtl/decoder_pkg.sv
// Shared types, mode constants and the range-checked one-hot helper used by
// the decoder_scan block.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest decoder the helper can serve; callers size-cast the result down.
  localparam int unsigned ONEHOT_MAX = 256;

  // One-hot of code within num_out outputs; all zero when code is out of range.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned code,
                                                   input int unsigned num_out);
    logic [ONEHOT_MAX-1:0] vec;
    vec = '0;
    for (int unsigned i = 0; i < ONEHOT_MAX; i++) begin
      vec[i] = (i == code) && (code < num_out);
    end
    return vec;
  endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Handshake and select bundle of decoder_scan. oor_err exists only when
// DECODE_OOR_FLAG_EN is defined.
interface decoder_scan_if #(
  parameter int unsigned NUM_OUT = 8
);
  localparam int unsigned CODE_W = $clog2(NUM_OUT);

  logic              en;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic [NUM_OUT-1:0] out;
  logic [CODE_W-1:0] idx;
  logic              scan_wrap;
`ifdef DECODE_OOR_FLAG_EN
  logic              oor_err;
`endif

  modport master (
    output en, mode, in_valid, in_code,
    input  in_ready, out, idx, scan_wrap
`ifdef DECODE_OOR_FLAG_EN
    , input oor_err
`endif
  );

  modport slave (
    input  en, mode, in_valid, in_code,
    output in_ready, out, idx, scan_wrap
`ifdef DECODE_OOR_FLAG_EN
    , output oor_err
`endif
  );

endinterface

// File: rtl/scan_timer.sv
// Dwell counter plus index counter for SCAN mode. The index advances after
// DWELL cycles and wraps NUM_OUT-1 -> 0 with a one-cycle wrap pulse that
// coincides with index 0 becoming visible.
module scan_timer #(
  parameter  int unsigned NUM_OUT = 8,
  parameter  int unsigned DWELL   = 4,
  localparam int unsigned CODE_W  = $clog2(NUM_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              restart,
  output logic [CODE_W-1:0] idx,
  output logic              wrap
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CNT_W-1:0] cnt;
  logic             last_dwell;
  logic             last_idx;

  assign last_dwell = (cnt == CNT_W'(DWELL - 1));
  assign last_idx   = (idx == CODE_W'(NUM_OUT - 1));

  // Count dwell cycles and step the index; restart or idle parks at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= '0;
      wrap <= 1'b0;
    end else if (restart || !run) begin
      cnt  <= '0;
      idx  <= '0;
      wrap <= 1'b0;
    end else if (last_dwell) begin
      cnt  <= '0;
      idx  <= last_idx ? '0 : idx + 1'b1;
      wrap <= last_idx;
    end else begin
      cnt  <= cnt + 1'b1;
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder for any output count, with a DIRECT
// (valid/ready code) mode and a SCAN (walking index with dwell) mode.
// Optional feature: define DECODE_OOR_FLAG_EN for the sticky oor_err flag.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int unsigned NUM_OUT = 8,
  parameter  int unsigned DWELL   = 4,
  localparam int unsigned CODE_W  = $clog2(NUM_OUT)
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);

  state_e state;
  state_e state_next;

  logic               ready;
  logic               accept;
  logic               in_range;
  logic               scan_run;
  logic               scan_restart;
  logic [NUM_OUT-1:0] code_hot;
  logic [NUM_OUT-1:0] scan_hot;
  logic [NUM_OUT-1:0] direct_out;
  logic [CODE_W-1:0]  direct_idx;
  logic [CODE_W-1:0]  scan_idx;
  logic               scan_wrap;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: en gates everything, mode picks the active mode every cycle.
  always_comb begin
    state_next = IDLE;
    if (bus.en) begin
      state_next = (bus.mode == MODE_SCAN) ? SCAN : DIRECT;
    end
  end

  // Handshake, scan control and decode of the incoming code / scan index.
  always_comb begin
    ready        = bus.en & (bus.mode == MODE_DIRECT);
    accept       = bus.in_valid & ready;
    in_range     = (32'(bus.in_code) < NUM_OUT);
    scan_restart = (state_next == SCAN) && (state != SCAN);
    scan_run     = (state_next == SCAN) && (state == SCAN);
    code_hot     = NUM_OUT'(onehot(32'(bus.in_code), NUM_OUT));
    scan_hot     = NUM_OUT'(onehot(32'(scan_idx), NUM_OUT));
  end

  scan_timer #(
    .NUM_OUT (NUM_OUT),
    .DWELL   (DWELL)
  ) u_scan_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (scan_run),
    .restart (scan_restart),
    .idx     (scan_idx),
    .wrap    (scan_wrap)
  );

  // DIRECT select register: loads on accept, otherwise holds; cleared whenever
  // the next state is not DIRECT so a fresh DIRECT entry shows out=0, idx=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      direct_out <= '0;
      direct_idx <= '0;
    end else if (state_next != DIRECT) begin
      direct_out <= '0;
      direct_idx <= '0;
    end else if (accept) begin
      direct_out <= code_hot;
      if (in_range) begin
        direct_idx <= bus.in_code;
      end
    end
  end

`ifdef DECODE_OOR_FLAG_EN
  logic oor_err;

  // Sticky out-of-range flag, cleared only by reset or en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_err <= 1'b0;
    end else if (!bus.en) begin
      oor_err <= 1'b0;
    end else if (accept && !in_range) begin
      oor_err <= 1'b1;
    end
  end

  assign bus.oor_err = oor_err;
`endif

  // Every source of out/idx is a flop; SCAN selects the timer index, other
  // states the DIRECT register (which is zero in IDLE).
  assign bus.in_ready  = ready;
  assign bus.out       = (state == SCAN) ? scan_hot : direct_out;
  assign bus.idx       = (state == SCAN) ? scan_idx : direct_idx;
  assign bus.scan_wrap = scan_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: two instances (NUM_OUT=8/DWELL=1 and
// NUM_OUT=6/DWELL=3) share one stimulus stream and are compared every cycle
// against an arithmetic reference model, plus literal checks of key cases.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;

  always #5 clk = ~clk;

  decoder_scan_if #(.NUM_OUT(8)) bus_a ();
  decoder_scan_if #(.NUM_OUT(6)) bus_b ();

  assign bus_a.en = en;
  assign bus_a.mode = mode;
  assign bus_a.in_valid = in_valid;
  assign bus_a.in_code = in_code;
  assign bus_b.en = en;
  assign bus_b.mode = mode;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_code = in_code;

  decoder_scan #(.NUM_OUT(8), .DWELL(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  decoder_scan #(.NUM_OUT(6), .DWELL(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state per instance (0 = A, 1 = B).
  logic [7:0] m_out [2];
  int         m_idx [2];
  bit         m_wrap[2];
  bit         m_oor [2];
  bit         m_scan[2];
  int         m_t   [2];
  logic [7:0] m_dout[2];
  int         m_didx[2];
  logic [7:0] one = 8'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs held during the edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int n;
      int dw;
      n  = (d == 0) ? 8 : 6;
      dw = (d == 0) ? 1 : 3;
      if (!rst_n || !en) begin
        m_scan[d] = 0; m_t[d] = 0; m_idx[d] = 0; m_out[d] = 0;
        m_wrap[d] = 0; m_dout[d] = 0; m_didx[d] = 0;
        m_oor[d]  = 0;
      end else if (mode) begin
        if (m_scan[d]) m_t[d]++;
        else begin
          m_scan[d] = 1;
          m_t[d] = 0;
        end
        m_idx[d]  = (m_t[d] / dw) % n;
        m_out[d]  = one << m_idx[d];
        m_wrap[d] = (m_t[d] > 0) && (m_t[d] % (dw * n) == 0);
        m_dout[d] = 0;
        m_didx[d] = 0;
      end else begin
        m_scan[d] = 0;
        m_wrap[d] = 0;
        if (in_valid) begin
          if (int'(in_code) < n) begin
            m_dout[d] = one << in_code;
            m_didx[d] = int'(in_code);
          end else begin
            m_dout[d] = 0;
            m_oor[d]  = 1;
          end
        end
        m_out[d] = m_dout[d];
        m_idx[d] = m_didx[d];
      end
    end
  endtask

  task automatic check_all();
    logic exp_ready;
    exp_ready = en & ~mode;
    chk("out_a", 32'(bus_a.out), 32'(m_out[0]));
    chk("out_b", 32'(bus_b.out), 32'(m_out[1]));
    chk("idx_a", 32'(bus_a.idx), m_idx[0]);
    chk("idx_b", 32'(bus_b.idx), m_idx[1]);
    chk("wrap_a", 32'(bus_a.scan_wrap), 32'(m_wrap[0]));
    chk("wrap_b", 32'(bus_b.scan_wrap), 32'(m_wrap[1]));
    chk("ready_a", 32'(bus_a.in_ready), 32'(exp_ready));
    chk("ready_b", 32'(bus_b.in_ready), 32'(exp_ready));
    chk("onehot_a", 32'($countones(bus_a.out) <= 1), 32'd1);
    chk("onehot_b", 32'($countones(bus_b.out) <= 1), 32'd1);
`ifdef DECODE_OOR_FLAG_EN
    chk("oor_a", 32'(bus_a.oor_err), 32'(m_oor[0]));
    chk("oor_b", 32'(bus_b.oor_err), 32'(m_oor[1]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int         codes[3];
    logic [7:0] t1_exp[3];
    int         seq_b[19];
    codes  = '{0, 3, 7};
    t1_exp = '{8'h01, 8'h08, 8'h80};
    seq_b  = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 8, 8, 8, 16, 16, 16, 32, 32, 32, 1};

    // Reset.
    tick();
    tick();
    chk("rst_out_a", 32'(bus_a.out), 32'd0);
    chk("rst_idx_b", 32'(bus_b.idx), 32'd0);
    rst_n = 1'b1;

    // DIRECT accepts 0,3,7 on A (B sees 7 as out of range).
    en = 1'b1;
    mode = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_code  = 3'(codes[i]);
      tick();
      chk("t1_out_a", 32'(bus_a.out), 32'(t1_exp[i]));
      in_valid = 1'b0;
      tick();
      chk("t1_hold_a", 32'(bus_a.out), 32'(t1_exp[i]));
    end
    chk("t1_out_b_oor", 32'(bus_b.out), 32'd0);

    // Out-of-range code 6 on B; en=0 clears the sticky flag.
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    in_valid = 1'b1;
    in_code  = 3'd6;
    tick();
    chk("t2_out_b", 32'(bus_b.out), 32'd0);
    chk("t2_out_a", 32'(bus_a.out), 32'h40);
`ifdef DECODE_OOR_FLAG_EN
    chk("t2_oor_set", 32'(bus_b.oor_err), 32'd1);
`endif
    in_code = 3'd2;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_out_b2", 32'(bus_b.out), 32'h04);
`ifdef DECODE_OOR_FLAG_EN
    chk("t2_oor_sticky", 32'(bus_b.oor_err), 32'd1);
`endif
    en = 1'b0;
    tick();
`ifdef DECODE_OOR_FLAG_EN
    chk("t2_oor_clr", 32'(bus_b.oor_err), 32'd0);
`endif
    chk("t2_idle_out_b", 32'(bus_b.out), 32'd0);

    // SCAN walk on B (DWELL=3) through a full wrap; input codes ignored.
    en = 1'b1;
    mode = 1'b1;
    for (int k = 0; k < 19; k++) begin
      in_valid = 1'b1;
      in_code  = 3'($urandom_range(0, 7));
      tick();
      chk("t3_seq_b", 32'(bus_b.out), 32'(seq_b[k]));
      chk("t3_wrap_b", 32'(bus_b.scan_wrap), 32'(k == 18));
      chk("t3_ready_b", 32'(bus_b.in_ready), 32'd0);
    end

    // Switch to DIRECT at idx=2 with a valid code in the switching cycle.
    en = 1'b0;
    tick();
    en = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    chk("t4_idx_b", 32'(bus_b.idx), 32'd2);
    mode = 1'b0;
    in_valid = 1'b1;
    in_code = 3'd1;
    #1;
    chk("t4_ready_b", 32'(bus_b.in_ready), 32'd1);
    tick();
    chk("t4_out_b", 32'(bus_b.out), 32'h02);
    chk("t4_out_a", 32'(bus_a.out), 32'h02);
    in_valid = 1'b0;

    // Drop en mid-scan, then resume scanning from index 0.
    mode = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    en = 1'b0;
    tick();
    chk("t5_out_b", 32'(bus_b.out), 32'd0);
    chk("t5_idx_b", 32'(bus_b.idx), 32'd0);
    en = 1'b1;
    tick();
    chk("t5_restart_b", 32'(bus_b.out), 32'd1);
    chk("t5_restart_idx", 32'(bus_b.idx), 32'd0);

    // Asynchronous reset mid-dwell clears outputs before the next edge.
    tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_b", 32'(bus_b.out), 32'd0);
    chk("t6_out_a", 32'(bus_a.out), 32'd0);
    chk("t6_idx_b", 32'(bus_b.idx), 32'd0);
    model_step();
    @(negedge clk);
    check_all();
    tick();
    rst_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      en       = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      in_valid = 1'($urandom_range(0, 1));
      in_code  = 3'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
